// File: rtl/arb_pkg.sv
// Shared constants and state type for the 8-way round-robin arbiter.
package arb_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;
  localparam int CNT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;
endpackage

// File: rtl/rr_arb8_pick.sv
// Combinational round-robin selector: lowest set request at or above ptr,
// wrapping to the lowest set request overall when nothing lies above ptr.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx,
  output logic [N_REQ-1:0] onehot
);

  logic [N_REQ-1:0] masked;
  logic [N_REQ-1:0] vec;

  always_comb begin
    masked = req & ({N_REQ{1'b1}} << ptr);
    vec    = (|masked) ? masked : req;
    any    = |req;
    idx    = '0;
    // Scan downward so the lowest set bit is the one that sticks.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
    onehot = any ? (N_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/rr_arb8.sv
// Eight-requester round-robin arbiter with grant hold, release on done or
// request drop, and an optional hold-time limit that revokes the grant.
module rr_arb8
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam logic             HOLD_EN   = (HOLD_MAX != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_EN ? CNT_W'(HOLD_MAX - 1) : '0;

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             tmo_q, tmo_d;

  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic [N_REQ-1:0] pick_onehot;
  logic             rel_c;
  logic             hit_c;

  rr_pick u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    tmo_d   = 1'b0;
    rel_c   = 1'b0;
    hit_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en && pick_any) begin
          gnt_d   = pick_onehot;
          idx_d   = pick_idx;
          ptr_d   = pick_idx + IDX_W'(1);
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        rel_c = done | ~req[idx_q] | ~en;
        hit_c = HOLD_EN && (cnt_q == HOLD_LAST);
        // A voluntary release on the same edge as the limit is not a timeout.
        if (rel_c || hit_c) begin
          state_d = IDLE;
          gnt_d   = '0;
          idx_d   = '0;
          tmo_d   = ~rel_c;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = |gnt_q;
  assign timeout   = tmo_q;

endmodule

// File: tb/tb_rr_arb8.sv
// Bench for rr_arb8: a behavioural arbiter model fills a scoreboard each cycle,
// plus directed checks on grant order, hold length and reset.
module tb_rr_arb8;

  localparam int HOLD = 16;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
    logic       tmo;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] req = '0;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int   total = 0;
  int   bad = 0;
  exp_t sb_q[$];

  int   m_own = -1;
  int   m_ptr = 0;
  int   m_len = 0;
  logic m_tmo = 1'b0;

  rr_arb8 #(.HOLD_MAX(HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_own = -1;
    m_ptr = 0;
    m_len = 0;
    m_tmo = 1'b0;
  endtask

  // Predicts the outputs that follow the coming edge from the current inputs.
  task automatic model_eval();
    exp_t e;
    m_tmo = 1'b0;
    if (m_own < 0) begin
      if (en && req != 0) begin
        for (int i = 0; i < 8; i++) begin
          int c;
          c = (m_ptr + i) % 8;
          if (req[c] && m_own < 0) begin
            m_own = c;
            m_ptr = (c + 1) % 8;
            m_len = 1;
          end
        end
      end
    end else if (done || !req[m_own] || !en) begin
      m_own = -1;
    end else if (HOLD != 0 && m_len == HOLD) begin
      m_own = -1;
      m_tmo = 1'b1;
    end else if (m_len < 255) begin
      m_len++;
    end
    e.gnt = (m_own >= 0) ? (8'b1 << m_own) : 8'h00;
    e.idx = (m_own >= 0) ? 3'(m_own) : 3'd0;
    e.vld = (m_own >= 0);
    e.tmo = m_tmo;
    sb_q.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    model_eval();
    @(posedge clk);
    #1;
    chk("sb_depth", sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("gnt", gnt, e.gnt);
      chk("gnt_idx", gnt_idx, e.idx);
      chk("gnt_valid", gnt_valid, e.vld);
      chk("timeout", timeout, e.tmo);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    done  = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int n;
    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_idx", gnt_idx, 0);
    chk("rst_vld", gnt_valid, 0);
    chk("rst_tmo", timeout, 0);
    rst_n = 1'b1;
    model_reset();

    // Asynchronous reset in the middle of a grant
    en = 1'b1;
    req = 8'hFF;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_gnt", gnt, 0);
    chk("arst_idx", gnt_idx, 0);
    chk("arst_vld", gnt_valid, 0);
    chk("arst_tmo", timeout, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    chk("arst_first_idx", gnt_idx, 0);
    chk("arst_first_vld", gnt_valid, 1);

    // Pointer advance with two requesters
    do_reset();
    req = 8'b0000_0101;
    step();
    chk("ptr_g0", gnt_idx, 0);
    done = 1'b1; step(); done = 1'b0;
    chk("ptr_gap0", gnt_valid, 0);
    step();
    chk("ptr_g2", gnt_idx, 2);
    done = 1'b1; step(); done = 1'b0;
    chk("ptr_gap1", gnt_valid, 0);
    step();
    chk("ptr_g0b", gnt_idx, 0);

    // Full rotation with all requesters active
    do_reset();
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      n = 0;
      step();
      while (!gnt_valid && n < 4) begin
        n++;
        step();
      end
      chk("rot_wait", (n < 4), 1);
      chk("rot_idx", gnt_idx, k % 8);
      chk("rot_onehot", $countones(gnt), 1);
      done = 1'b1; step(); done = 1'b0;
    end

    // Hold limit revokes a lone requester
    do_reset();
    req = 8'b0000_1000;
    step();
    n = 0;
    while (gnt == 8'h08 && n < 40) begin
      n++;
      step();
    end
    chk("tmo_len", n, HOLD);
    chk("tmo_pulse", timeout, 1);
    step();
    chk("tmo_regrant", gnt, 8'h08);
    chk("tmo_clear", timeout, 0);

    // Done on the final allowed cycle is a normal release
    do_reset();
    req = 8'b0000_1000;
    step();
    repeat (HOLD - 1) step();
    chk("sim_held", gnt, 8'h08);
    done = 1'b1; step(); done = 1'b0;
    chk("sim_tmo", timeout, 0);
    chk("sim_rel", gnt_valid, 0);
    req = 8'hFF;
    step();
    chk("sim_ptr4", gnt_idx, 4);

    // Enable drop and owner request drop
    do_reset();
    req = 8'hFF;
    step();
    step();
    chk("en_g0", gnt_idx, 0);
    en = 1'b0;
    step();
    chk("en_rel", gnt_valid, 0);
    chk("en_tmo", timeout, 0);
    repeat (3) begin
      step();
      chk("en_hold", gnt, 0);
    end
    en = 1'b1;
    step();
    chk("en_g1", gnt_idx, 1);
    req = 8'hFD;
    step();
    chk("rq_rel", gnt_valid, 0);
    step();
    chk("rq_g2", gnt_idx, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
